// File: rtl/jtag_debug_cmd_queue_if.sv
// Command stream from the debug receiver to its consumer: FWFT head entry
// with a valid/ready handshake.
interface jtag_debug_cmd_queue_if #(
    parameter int DATA_W = 38,
    parameter int IR_W   = 2
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_data;
    logic [IR_W-1:0]   cmd_ir;
    logic              cmd_is_dr;

    modport master (
        output cmd_valid, cmd_data, cmd_ir, cmd_is_dr,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_data, cmd_ir, cmd_is_dr,
        output cmd_ready
    );
endinterface

// File: rtl/jtag_debug_cmd_queue.sv
// System-clock receiver for the virtual-JTAG debug channel: synchronises the
// update strobes, captures DR/IR updates and queues them in a FWFT FIFO.
module jtag_debug_cmd_queue #(
    parameter int DATA_W      = 38,
    parameter int IR_W        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [DATA_W-1:0]                  sr,
    input  logic [IR_W-1:0]                    ir_in,
    input  logic                               vs_udr,
    input  logic                               vs_uir,
    jtag_debug_cmd_queue_if.master             cmd,
    output logic [2**IR_W-1:0]                 act_strobe,
    output logic                               overflow,
    input  logic                               overflow_clr,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [IR_W-1:0]   ir;
        logic              is_dr;
    } entry_t;

    logic [SYNC_STAGES-1:0] udr_sync;
    logic [SYNC_STAGES-1:0] uir_sync;
    logic                   udr_edge;
    logic                   uir_edge;
    logic                   udr_evt;
    logic                   uir_evt;

    entry_t                 dr_entry;
    entry_t                 ir_entry;
    entry_t                 pend_entry;
    logic                   pend_valid;
    entry_t                 pend_in;
    logic                   pend_load;
    entry_t                 wr_entry;
    logic                   wr_req;
    logic                   wr_en;
    logic                   lost;
    logic                   drop;

    entry_t                 mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [LVL_W-1:0]       level;
    logic                   full;
    logic                   pop;
    entry_t                 head;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            udr_sync <= '0;
            uir_sync <= '0;
            udr_edge <= 1'b0;
            uir_edge <= 1'b0;
        end else begin
            udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
            uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
            udr_edge <= udr_sync[SYNC_STAGES-1];
            uir_edge <= uir_sync[SYNC_STAGES-1];
        end
    end

    assign udr_evt  = udr_sync[SYNC_STAGES-1] & ~udr_edge;
    assign uir_evt  = uir_sync[SYNC_STAGES-1] & ~uir_edge;
    assign dr_entry = '{data: sr, ir: ir_in, is_dr: 1'b1};
    assign ir_entry = '{data: '0, ir: ir_in, is_dr: 1'b0};

    // Pending entry always goes first; a new event then takes its slot. Two
    // new events on top of a pending one cannot all fit, so the IR one is lost.
    always_comb begin
        wr_req    = 1'b0;
        wr_entry  = '0;
        pend_load = 1'b0;
        pend_in   = '0;
        lost      = 1'b0;
        if (pend_valid) begin
            wr_req   = 1'b1;
            wr_entry = pend_entry;
            if (udr_evt) begin
                pend_load = 1'b1;
                pend_in   = dr_entry;
                lost      = uir_evt;
            end else if (uir_evt) begin
                pend_load = 1'b1;
                pend_in   = ir_entry;
            end
        end else if (udr_evt) begin
            wr_req   = 1'b1;
            wr_entry = dr_entry;
            if (uir_evt) begin
                pend_load = 1'b1;
                pend_in   = ir_entry;
            end
        end else if (uir_evt) begin
            wr_req   = 1'b1;
            wr_entry = ir_entry;
        end
    end

    assign full  = (level == LVL_W'(FIFO_DEPTH));
    assign pop   = cmd.cmd_valid & cmd.cmd_ready;
    assign wr_en = wr_req & (~full | pop);
    assign drop  = (wr_req & ~wr_en) | lost;
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_valid <= 1'b0;
            pend_entry <= '0;
        end else begin
            pend_valid <= pend_load;
            if (pend_load) begin
                pend_entry <= pend_in;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_strobe <= '0;
            overflow   <= 1'b0;
        end else begin
            act_strobe <= '0;
            if (pop && head.is_dr) begin
                act_strobe[head.ir] <= 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    assign cmd.cmd_valid = (level != '0);
    assign cmd.cmd_data  = head.data;
    assign cmd.cmd_ir    = head.ir;
    assign cmd.cmd_is_dr = head.is_dr;
    assign fifo_level    = level;
endmodule

// File: tb/tb_jtag_debug_cmd_queue.sv
// Directed bench for jtag_debug_cmd_queue: latency, coincident strobes,
// overflow, full-with-pop across pointer wrap, and asynchronous reset.
module tb_jtag_debug_cmd_queue;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] sr;
    logic [1:0]  ir_in;
    logic        vs_udr;
    logic        vs_uir;
    logic [3:0]  act_strobe;
    logic        overflow;
    logic        overflow_clr;
    logic [2:0]  fifo_level;

    int tests = 0;
    int fails = 0;

    jtag_debug_cmd_queue_if #(.DATA_W(38), .IR_W(2)) cmd_if ();

    jtag_debug_cmd_queue #(
        .DATA_W(38), .IR_W(2), .SYNC_STAGES(2), .FIFO_DEPTH(4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sr           (sr),
        .ir_in        (ir_in),
        .vs_udr       (vs_udr),
        .vs_uir       (vs_uir),
        .cmd          (cmd_if),
        .act_strobe   (act_strobe),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Raise vs_udr for two clocks, then hold sr stable while the strobe drains.
    task automatic dr_update(input logic [37:0] d, input logic [1:0] ir);
        sr = d;
        ir_in = ir;
        vs_udr = 1'b1;
        tick();
        tick();
        vs_udr = 1'b0;
        for (int i = 0; i < 5; i++) tick();
    endtask

    initial begin
        reset_n = 1'b0;
        sr = '0;
        ir_in = '0;
        vs_udr = 1'b0;
        vs_uir = 1'b0;
        overflow_clr = 1'b0;
        cmd_if.cmd_ready = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Reset / idle
        check("rst_valid", cmd_if.cmd_valid, 0);
        check("rst_level", fifo_level, 0);
        check("rst_act", act_strobe, 0);
        check("rst_ovf", overflow, 0);
        check("rst_data", cmd_if.cmd_data, 0);

        // Single DR update, consumer always ready
        cmd_if.cmd_ready = 1'b1;
        sr = 38'h2A_DEAD_BEEF;
        ir_in = 2'd2;
        vs_udr = 1'b1;
        tick();
        check("dr_e1_valid", cmd_if.cmd_valid, 0);
        tick();
        check("dr_e2_valid", cmd_if.cmd_valid, 0);
        tick();
        check("dr_e3_valid", cmd_if.cmd_valid, 1);
        check("dr_e3_data", cmd_if.cmd_data, 38'h2A_DEAD_BEEF);
        check("dr_e3_ir", cmd_if.cmd_ir, 2);
        check("dr_e3_isdr", cmd_if.cmd_is_dr, 1);
        check("dr_e3_level", fifo_level, 1);
        tick();
        vs_udr = 1'b0;
        check("dr_e4_act", act_strobe, 4'b0100);
        check("dr_e4_valid", cmd_if.cmd_valid, 0);
        tick();
        check("dr_e5_act", act_strobe, 0);
        for (int i = 0; i < 4; i++) tick();
        check("dr_once_valid", cmd_if.cmd_valid, 0);
        check("dr_once_level", fifo_level, 0);

        // Coincident update-DR and update-IR
        cmd_if.cmd_ready = 1'b0;
        sr = 38'h01_2345_6789;
        ir_in = 2'd1;
        vs_udr = 1'b1;
        vs_uir = 1'b1;
        tick();
        tick();
        tick();
        check("sim_e3_level", fifo_level, 1);
        check("sim_e3_isdr", cmd_if.cmd_is_dr, 1);
        check("sim_e3_data", cmd_if.cmd_data, 38'h01_2345_6789);
        tick();
        vs_udr = 1'b0;
        vs_uir = 1'b0;
        check("sim_e4_level", fifo_level, 2);
        check("sim_e4_ir", cmd_if.cmd_ir, 1);
        check("sim_e4_isdr_stable", cmd_if.cmd_is_dr, 1);
        for (int i = 0; i < 4; i++) tick();
        check("sim_level_hold", fifo_level, 2);
        cmd_if.cmd_ready = 1'b1;
        tick();
        check("sim_pop1_act", act_strobe, 4'b0010);
        check("sim_pop1_isdr", cmd_if.cmd_is_dr, 0);
        check("sim_pop1_ir", cmd_if.cmd_ir, 1);
        check("sim_pop1_data", cmd_if.cmd_data, 0);
        check("sim_pop1_level", fifo_level, 1);
        tick();
        check("sim_pop2_act", act_strobe, 0);
        check("sim_pop2_valid", cmd_if.cmd_valid, 0);
        cmd_if.cmd_ready = 1'b0;

        // Overflow: five updates into a four-entry queue
        for (int i = 1; i <= 5; i++) dr_update(38'(i), 2'd3);
        check("ovf_level", fifo_level, 4);
        check("ovf_flag", overflow, 1);
        cmd_if.cmd_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("ovf_drain_data", cmd_if.cmd_data, 64'(i));
            tick();
        end
        cmd_if.cmd_ready = 1'b0;
        check("ovf_empty", cmd_if.cmd_valid, 0);
        check("ovf_last_act", act_strobe, 4'b1000);
        check("ovf_still_set", overflow, 1);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        check("ovf_cleared", overflow, 0);

        // Full queue, pop coinciding with a write, across pointer wrap
        for (int i = 1; i <= 4; i++) dr_update(38'h10 + 38'(i), 2'd0);
        check("full_level", fifo_level, 4);
        sr = 38'h15;
        ir_in = 2'd0;
        vs_udr = 1'b1;
        tick();
        tick();
        cmd_if.cmd_ready = 1'b1;
        tick();
        cmd_if.cmd_ready = 1'b0;
        vs_udr = 1'b0;
        check("fp_level", fifo_level, 4);
        check("fp_act", act_strobe, 4'b0001);
        for (int i = 0; i < 5; i++) tick();
        check("fp_ovf", overflow, 0);
        cmd_if.cmd_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            check("fp_order", cmd_if.cmd_data, 64'h10 + 64'(i));
            tick();
        end
        cmd_if.cmd_ready = 1'b0;
        check("fp_empty", fifo_level, 0);

        // Reset mid-queue
        for (int i = 1; i <= 3; i++) dr_update(38'h20 + 38'(i), 2'd2);
        check("mid_level", fifo_level, 3);
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", cmd_if.cmd_valid, 0);
        check("mid_rst_level", fifo_level, 0);
        tick();
        reset_n = 1'b1;
        cmd_if.cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mid_post_act", act_strobe, 0);
        end
        check("mid_post_valid", cmd_if.cmd_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/jtag_debug_cmd_queue.md
Name: jtag_debug_cmd_queue

Overview:
- System-clock-side receiver for the CPU's virtual-JTAG debug channel.
- Synchronises the TCK-domain update strobes (vs_udr, vs_uir) into clk and captures the shift-register contents and IR value on each update.
- Queues captured commands in a first-word-fall-through FIFO with valid/ready output and per-IR one-hot action strobes.
- Parametrised successor of the fixed 38-bit, 2-bit-IR, unbuffered sysclk decoder; it adds buffering, backpressure and overflow reporting.

Parameters:
DATA_W, 38, width of sr / cmd_data
IR_W, 2, width of ir_in / cmd_ir; action strobe count = 2**IR_W
SYNC_STAGES, 2, flip-flops per strobe synchroniser, allowed range 2..4
FIFO_DEPTH, 4, command FIFO entries, power of two, at least 2

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
sr  in  DATA_W  TCK-domain shift register; stable while vs_udr is high and for at least SYNC_STAGES+2 clk cycles afterwards
ir_in  in  IR_W  TCK-domain virtual IR; same stability rule, relative to vs_udr and vs_uir
vs_udr  in  1  asynchronous update-DR level pulse
vs_uir  in  1  asynchronous update-IR level pulse
cmd_ready  in  1  consumer accepts the head entry
cmd_valid  out  1  FIFO not empty
cmd_data  out  DATA_W  head entry data (all zeros for IR entries)
cmd_ir  out  IR_W  head entry IR value
cmd_is_dr  out  1  1 = update-DR entry, 0 = update-IR entry
act_strobe  out  2**IR_W  one-cycle one-hot pulse, bit cmd_ir, on pop of a DR entry
overflow  out  1  sticky: at least one event was dropped
overflow_clr  in  1  synchronous clear of overflow
fifo_level  out  clog2(FIFO_DEPTH+1)  current entry count

Behaviour:
- Reset values: all outputs 0, synchronisers 0, FIFO empty, pending register empty. Reset asserted mid-operation discards all entries immediately, including any pending one.
- Synchronisers: vs_udr and vs_uir each pass through a SYNC_STAGES flip-flop chain, followed by an edge register.
  - udr_evt / uir_evt = sync_out & ~edge_reg.
  - One event per rising edge; a held-high level produces no repeat events.
- Capture: in the event cycle, {sr, ir_in, is_dr=1} is sampled for udr_evt; {0, ir_in, is_dr=0} for uir_evt.
- Write path: one FIFO write per cycle.
  - If udr_evt and uir_evt coincide, the DR entry is written now and the IR entry goes to a 1-entry pending register, written the next cycle ahead of any new event.
  - If a new event arrives while pending is occupied, the pending entry is written first and the new event becomes pending; no loss while the FIFO has space.
- Latency: the first clk edge sampling vs_udr high is edge 1. The entry is written at edge SYNC_STAGES+1, so cmd_valid rises after that edge (edge 3 with default parameters).
- Handshake:
  - pop = cmd_valid & cmd_ready.
  - Head outputs are stable while cmd_valid=1 and cmd_ready=0.
  - cmd_ready with cmd_valid=0 has no effect.
- act_strobe: registered; asserted the cycle after a pop of a DR entry; bit index = popped cmd_ir. IR-entry pops produce no strobe.
- Full boundary:
  - A write to a full FIFO with a simultaneous pop is accepted and the level is unchanged.
  - A write to a full FIFO without a pop drops the entry and sets overflow on the next edge.
  - A dropped pending entry also sets overflow.
- overflow: overflow_clr clears it. If a drop and overflow_clr occur in the same cycle, set wins.
- fifo_level: equals writes minus pops; never exceeds FIFO_DEPTH; read/write pointers wrap modulo FIFO_DEPTH.
- Empty boundary: a write to an empty FIFO makes the entry visible the next cycle; there is no same-cycle bypass.

Test Plan:
- Reset, idle: after reset_n released, cmd_valid=0, fifo_level=0, act_strobe=0, overflow=0.
- Single DR update: sr=38'h2A_DEAD_BEEF, ir_in=2, vs_udr high 4 clks, cmd_ready=1 -> cmd_valid high at edge 3 with cmd_data=38'h2A_DEAD_BEEF, cmd_ir=2, cmd_is_dr=1; act_strobe=4'b0100 for exactly one cycle; only one entry produced.
- Simultaneous strobes: vs_udr and vs_uir rise together with ir_in=1 -> two entries in order: DR (is_dr=1, ir=1), then IR (is_dr=0, data=0); fifo_level reaches 2 with cmd_ready=0.
- Overflow: cmd_ready=0, 5 distinct DR updates with data 1..5 -> fifo_level=4, overflow=1, drain yields data 1,2,3,4; overflow_clr pulse -> overflow=0.
- Full with concurrent pop: FIFO full, one cmd_ready pulse coinciding with a write -> fifo_level stays 4, overflow stays 0, entry order preserved across pointer wrap.
- Reset mid-queue: 3 entries queued, reset_n low 1 clk -> cmd_valid=0, fifo_level=0 immediately; no act_strobe after release.
